bool_tt_monitor: RTL and testbench

Truth-table monitor for 3-input single-output boolean blocks, the checking end of the stimulus benches that sweep `a`/`b`/`c`. It watches the DUT's inputs and output, waits for each input combination to settle, and records the settled output per row. It compares each recorded row against a parameterised expected truth table and reports done, pass, first failing row, and mismatch count. It sits beside the DUT in the bench, or on-board behind the switch/LED wiring, and never drives the DUT.

---
 rtl/bool_tt_mon_pkg.sv | 16 +
 rtl/bool_tt_mon_sync.sv | 26 ++
 rtl/bool_tt_monitor.sv | 186 ++++++++++++++++++
 tb/tb_bool_tt_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bool_tt_mon_pkg.sv
// Shared types and limits for the 3-input truth-table monitor.
package bool_tt_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int ROW_W  = 3;
  localparam int N_ROWS = 8;

  localparam logic [3:0] MISMATCH_MAX = 4'd15;
  localparam logic [7:0] GLITCH_MAX   = 8'd255;

endpackage

// File: rtl/bool_tt_mon_sync.sv
// Two-flop synchroniser for a W-bit vector of signals asynchronous to clk.
module bool_tt_mon_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/bool_tt_monitor.sv
// Truth-table monitor: captures the settled output of a 3-input block per row
// and checks it against EXPECTED. Optional glitch counter: BOOL_TT_MON_GLITCH_EN.
module bool_tt_monitor
  import bool_tt_mon_pkg::*;
#(
  parameter logic [N_ROWS-1:0] EXPECTED = 8'hE8,
  parameter int                SETTLE   = 4,
  parameter int                TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              a,
  input  logic              b,
  input  logic              c,
  input  logic              e,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [N_ROWS-1:0] seen,
  output logic [3:0]        mismatch_cnt,
  output logic [ROW_W-1:0]  fail_idx,
  output logic [7:0]        glitch_cnt
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SETTLE_V   = SW'(SETTLE);
  localparam logic [SW-1:0] SETTLE_M1  = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);

  logic [3:0] v;
  logic [3:0] v_prev_q;
  logic [SW-1:0] stab_q, stab_d;
  logic changed;
  logic strobe;
  logic [ROW_W-1:0] cap_idx;
  logic cap_e;

  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [N_ROWS-1:0] seen_q, seen_d;
  logic [3:0] mism_q, mism_d;
  logic [ROW_W-1:0] fail_idx_q, fail_idx_d;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic timeout_q, timeout_d;

  bool_tt_mon_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({a, b, c, e}),
    .q   (v)
  );

  // A capture fires once per stable period, on the SETTLE-1 -> SETTLE step.
  always_comb begin
    changed = (v != v_prev_q);
    strobe  = !changed && (stab_q == SETTLE_M1);
    cap_idx = v[3:1];
    cap_e   = v[0];
    if (changed) begin
      stab_d = '0;
    end else if (stab_q == SETTLE_V) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    seen_d     = seen_q;
    mism_d     = mism_q;
    fail_idx_d = fail_idx_q;
    done_d     = done_q;
    pass_d     = pass_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_RUN;
          timer_d    = '0;
          seen_d     = '0;
          mism_d     = '0;
          fail_idx_d = '0;
          done_d     = 1'b0;
          pass_d     = 1'b0;
          timeout_d  = 1'b0;
        end
      end
      ST_RUN: begin
        timer_d = timer_q + 1'b1;
        if (strobe && !seen_q[cap_idx]) begin
          seen_d[cap_idx] = 1'b1;
          if (cap_e != EXPECTED[cap_idx]) begin
            if (mism_q != MISMATCH_MAX) begin
              mism_d = mism_q + 1'b1;
            end
            if (mism_q == '0) begin
              fail_idx_d = cap_idx;
            end
          end
        end
        // Completion takes priority over a coincident timeout.
        if (&seen_d) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          pass_d  = (mism_d == '0);
        end else if (timer_q == TIMEOUT_M1) begin
          state_d   = ST_DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
          pass_d    = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_prev_q   <= '0;
      stab_q     <= '0;
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      seen_q     <= '0;
      mism_q     <= '0;
      fail_idx_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      v_prev_q   <= v;
      stab_q     <= stab_d;
      state_q    <= state_d;
      timer_q    <= timer_d;
      seen_q     <= seen_d;
      mism_q     <= mism_d;
      fail_idx_q <= fail_idx_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef BOOL_TT_MON_GLITCH_EN
  logic [7:0] glitch_q, glitch_d;

  // A change while 0 < stab < SETTLE abandons a value that never got captured.
  always_comb begin
    glitch_d = glitch_q;
    if (state_q != ST_RUN) begin
      if (start) begin
        glitch_d = '0;
      end
    end else if (changed && (stab_q != '0) && (stab_q < SETTLE_V) &&
                 (glitch_q != GLITCH_MAX)) begin
      glitch_d = glitch_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  assign glitch_cnt = 8'd0;
`endif

  assign done         = done_q;
  assign pass         = pass_q;
  assign timeout      = timeout_q;
  assign seen         = seen_q;
  assign mismatch_cnt = mism_q;
  assign fail_idx     = fail_idx_q;

endmodule

// File: tb/tb_bool_tt_monitor.sv
// Randomised bench for bool_tt_monitor with a run-length based reference model
// and literal checks for reset, clean sweep, fault, timeout, glitch and mid-sweep reset.
module tb_bool_tt_monitor;

  localparam int         SETTLE  = 4;
  localparam int         TIMEOUT = 200;
  localparam logic [7:0] EXP     = 8'hE8;
`ifdef BOOL_TT_MON_GLITCH_EN
  localparam int GLITCH_EXP = 1;
`else
  localparam int GLITCH_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic a, b, c, e;
  logic done, pass, timeout;
  logic [7:0] seen;
  logic [3:0] mismatch_cnt;
  logic [2:0] fail_idx;
  logic [7:0] glitch_cnt;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;
  int order[8];

  bool_tt_monitor #(
    .EXPECTED (EXP),
    .SETTLE   (SETTLE),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a            (a),
    .b            (b),
    .c            (c),
    .e            (e),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .seen         (seen),
    .mismatch_cnt (mismatch_cnt),
    .fail_idx     (fail_idx),
    .glitch_cnt   (glitch_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: v is the input vector two edges late; a value is captured
  // once it has been present in v for SETTLE+1 consecutive cycles.
  logic [3:0] in_d1, vcur;
  int vrun, prev_run, run_cycles;
  bit m_run, m_done, m_pass, m_timeout;
  logic [7:0] m_seen;
  int m_mism, m_fail, m_glitch;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      in_d1 = '0; vcur = '0; vrun = 2; prev_run = 0; run_cycles = 0;
      m_run = 0; m_done = 0; m_pass = 0; m_timeout = 0;
      m_seen = '0; m_mism = 0; m_fail = 0; m_glitch = 0;
    end else begin
      if (!m_run) begin
        if (start) begin
          m_run = 1; run_cycles = 0; m_done = 0; m_pass = 0; m_timeout = 0;
          m_seen = '0; m_mism = 0; m_fail = 0; m_glitch = 0;
        end
      end else begin
        run_cycles++;
`ifdef BOOL_TT_MON_GLITCH_EN
        if (vrun == 1 && prev_run >= 2 && prev_run <= SETTLE && m_glitch < 255) m_glitch++;
`endif
        if (vrun == SETTLE + 1 && !m_seen[vcur[3:1]]) begin
          m_seen[vcur[3:1]] = 1'b1;
          if (vcur[0] != EXP[vcur[3:1]]) begin
            if (m_mism == 0) m_fail = int'(vcur[3:1]);
            if (m_mism < 15) m_mism++;
          end
        end
        if (m_seen == 8'hFF) begin
          m_run = 0; m_done = 1; m_pass = (m_mism == 0);
        end else if (run_cycles == TIMEOUT) begin
          m_run = 0; m_done = 1; m_timeout = 1; m_pass = 0;
        end
      end
      if (in_d1 != vcur) begin
        prev_run = vrun;
        vrun = 1;
      end else begin
        vrun++;
      end
      vcur = in_d1;
      in_d1 = {a, b, c, e};
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if (done !== m_done || pass !== m_pass || timeout !== m_timeout || seen !== m_seen ||
          mismatch_cnt !== 4'(m_mism) || fail_idx !== 3'(m_fail) || glitch_cnt !== 8'(m_glitch)) begin
        fails++;
        $display("FAIL cycle_model t=%0t dut: done=%b pass=%b to=%b seen=%h mm=%0d fi=%0d gl=%0d required: done=%b pass=%b to=%b seen=%h mm=%0d fi=%0d gl=%0d",
                 $time, done, pass, timeout, seen, mismatch_cnt, fail_idx, glitch_cnt,
                 m_done, m_pass, m_timeout, m_seen, m_mism, m_fail, m_glitch);
      end
    end
  end

  function automatic logic maj(input logic [2:0] r);
    return (r[2] & r[1]) | (r[2] & r[0]) | (r[1] & r[0]);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] row, input logic ev, input int hold);
    {a, b, c} = row;
    e = ev;
    tick(hold);
  endtask

  // Park on the first row with the wrong output so the sweep's first row is a fresh change.
  task automatic park_start(input logic [2:0] first_row);
    drive(first_row, ~maj(first_row), SETTLE + 4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (done !== 1'b1 && n < 400) begin
      tick(1);
      n++;
    end
    tests++;
    if (done !== 1'b1) begin
      fails++;
      $display("FAIL %s: done=%b after %0d cycles, required 1", name, done, n);
    end
  endtask

  task automatic shuffle();
    for (int i = 0; i < 8; i++) order[i] = i;
    for (int i = 7; i > 0; i--) begin
      int j, t;
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
  endtask

  function automatic int outs_word();
    return int'({done, pass, timeout, seen, mismatch_cnt, fail_idx, glitch_cnt});
  endfunction

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; {a, b, c, e} = 4'b0;

    // Reset with random inputs
    repeat (6) begin
      {a, b, c, e} = 4'($urandom);
      tick(1);
      chk_en = 1;
    end
    chk("reset_outs", outs_word(), 0);
    rst = 1'b0;
    tick(100);
    chk("idle_no_start_outs", outs_word(), 0);

    // Clean sweep, rows 0..7 in order
    park_start(3'd0);
    for (int r = 0; r < 8; r++) drive(3'(r), maj(3'(r)), 10);
    wait_done("clean_done", n);
    chk("clean_seen", int'(seen), 8'hFF);
    chk("clean_pass", int'(pass), 1);
    chk("clean_mism", int'(mismatch_cnt), 0);
    chk("clean_timeout", int'(timeout), 0);

    // Fault on row 5, then revisit row 5 with the right value
    park_start(3'd0);
    for (int r = 0; r < 5; r++) drive(3'(r), maj(3'(r)), 10);
    drive(3'd5, ~maj(3'd5), 10);
    drive(3'd5, maj(3'd5), 10);
    for (int r = 6; r < 8; r++) drive(3'(r), maj(3'(r)), 10);
    wait_done("fault_done", n);
    chk("fault_mism", int'(mismatch_cnt), 1);
    chk("fault_idx", int'(fail_idx), 5);
    chk("fault_pass", int'(pass), 0);
    chk("fault_done_hi", int'(done), 1);

    // Timeout: row 7 never shown
    park_start(3'd0);
    for (int r = 0; r < 7; r++) drive(3'(r), maj(3'(r)), 10);
    wait_done("timeout_done", n);
    chk("timeout_cycles", 70 + n, TIMEOUT);
    chk("timeout_flag", int'(timeout), 1);
    chk("timeout_seen", int'(seen), 8'h7F);
    chk("timeout_pass", int'(pass), 0);

    // Glitch: row 3 too short to settle, row 2 long enough
    park_start(3'd3);
    drive(3'd3, maj(3'd3), 3);
    drive(3'd2, maj(3'd2), 10);
    chk("glitch_seen", int'(seen), 8'h04);
    chk("glitch_cnt", int'(glitch_cnt), GLITCH_EXP);
    wait_done("glitch_timeout_done", n);

    // Mid-sweep reset, then a fresh full sweep
    shuffle();
    park_start(3'(order[0]));
    for (int i = 0; i < 4; i++) drive(3'(order[i]), maj(3'(order[i])), 10);
    chk("mid_rows_seen", $countones(seen), 4);
    rst = 1'b1;
    #1;
    chk("mid_reset_outs", outs_word(), 0);
    tick(2);
    rst = 1'b0;
    tick(10);
    shuffle();
    park_start(3'(order[0]));
    chk("restart_seen_clear", int'(seen), 0);
    for (int i = 0; i < 8; i++) drive(3'(order[i]), maj(3'(order[i])), $urandom_range(SETTLE + 2, 12));
    wait_done("restart_done", n);
    chk("restart_pass", int'(pass), 1);
    chk("restart_seen", int'(seen), 8'hFF);

    // Random traffic: rows, holds, wrong outputs, starts and resets
    repeat (400) begin
      int r;
      logic [2:0] row;
      r = $urandom_range(0, 99);
      if (r < 5) begin
        start = 1'b1;
        tick(1);
        start = 1'b0;
      end else if (r < 7) begin
        rst = 1'b1;
        tick($urandom_range(1, 3));
        rst = 1'b0;
      end else begin
        row = 3'($urandom);
        drive(row, ($urandom_range(0, 9) == 0) ? ~maj(row) : maj(row), $urandom_range(1, 12));
      end
    end

    tick(2);
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
